instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have the port PC_clr, input, 1 bit: clear PC to 0x00 (from controller).
REQ-004 The module SHALL have the port PC_up, input, 1 bit: increment PC (from controller).
REQ-005 The module SHALL have the port IR_ld, input, 1 bit: request fetch of instruction at PC into IR (from controller).
REQ-006 The module SHALL have the port M_data, input, 16 bits: instruction memory read data.
REQ-007 The module SHALL have the port M_ack, input, 1 bit: instruction memory read-complete strobe.
REQ-008 The module SHALL have the port M_rd_en, output, 1 bit: instruction memory read request.
REQ-009 The module SHALL have the port M_addr, output, 8 bits: instruction memory read address.
REQ-010 The module SHALL have the port PC, output, 8 bits: current program counter.
REQ-011 The module SHALL have the port IR, output, 16 bits: instruction register, driving the controller instruction input.
REQ-012 The module SHALL have the port IR_valid, output, 1 bit: IR holds a successfully fetched instruction.
REQ-013 The module SHALL have the port Fetch_busy, output, 1 bit: fetch in progress.
REQ-014 The module SHALL have the port Fetch_err, output, 1 bit: one-cycle pulse on fetch timeout.
REQ-015 The module SHALL have the port Halted, output, 1 bit: HALT opcode fetched (see Configuration).

Function
REQ-016 PC SHALL update each edge with priority PC_clr > PC_up: PC_clr -> 0x00; PC_up -> PC+1 modulo 256 (0xFF -> 0x00); otherwise hold.
REQ-017 The FSM SHALL have states IDLE, REQ and ERR, encoded as 2 bits.
REQ-018 In IDLE, IR_ld=1 SHALL snapshot PC into M_addr, clear IR_valid and move to REQ on the same edge.
REQ-019 In REQ, M_rd_en SHALL be 1 and M_addr SHALL be held constant, even if PC changes.
REQ-020 In REQ, M_ack=1 SHALL load M_data into IR, set IR_valid=1 and return to IDLE.
REQ-021 Minimum latency SHALL be two edges: IR_ld sampled at edge k, M_ack high before edge k+1 -> IR valid after edge k+1.
REQ-022 A 4-bit wait counter SHALL reset on entry to REQ and increment each REQ cycle without M_ack.
REQ-023 On the 16th REQ cycle without M_ack, the FSM SHALL move to ERR; IR SHALL be unchanged and IR_valid SHALL be 0.
REQ-024 ERR SHALL last exactly one cycle with Fetch_err=1, then return to IDLE.
REQ-025 Fetch_busy SHALL be 1 in REQ and ERR and 0 in IDLE.
REQ-026 IR_ld while not in IDLE SHALL be ignored; it is neither queued nor restarted.
REQ-027 PC_clr during REQ SHALL update PC and SHALL NOT abort the outstanding fetch.
REQ-028 PC_clr SHALL also clear IR_valid, except when the same edge completes a fetch; in that case IR_valid=1 takes precedence.
REQ-029 M_ack while in IDLE or ERR SHALL be ignored.
REQ-030 M_rd_en SHALL be 0 in IDLE and ERR.

Reset
REQ-031 Reset=0 SHALL immediately, without a clock edge, force: PC=0x00, IR=0x0000, IR_valid=0, M_rd_en=0, M_addr=0x00, Fetch_busy=0, Fetch_err=0, Halted=0, FSM=IDLE, wait counter=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the fetch; a late M_ack after release SHALL be ignored.
REQ-033 After Reset deasserts, normal operation SHALL begin on the first rising edge.

Configuration
REQ-034 With macro IF_HALT_DETECT_EN defined, loading IR with IR[15:12]=4'b0101 SHALL set Halted=1.
REQ-035 With IF_HALT_DETECT_EN defined, PC_up SHALL be ignored while Halted=1, and Halted SHALL clear only on PC_clr or Reset.
REQ-036 Without IF_HALT_DETECT_EN, Halted SHALL be tied to 0 and PC_up SHALL always be honored.

Verification
REQ-037 The bench SHALL cover reset then PC_up for 3 cycles -> PC=0x03; PC_clr and PC_up together -> PC=0x00.
REQ-038 The bench SHALL cover PC=0x05, IR_ld pulse, memory returns M_ack with 0x3123 two cycles later -> M_addr=0x05 throughout REQ, IR=0x3123, IR_valid=1, Fetch_busy low afterwards.
REQ-039 The bench SHALL cover IR_ld with M_ack never asserted -> M_rd_en high for 16 cycles, Fetch_err pulses for one cycle, IR unchanged, IR_valid=0.
REQ-040 The bench SHALL cover PC=0xFF with PC_up -> PC=0x00; PC_up during REQ -> PC advances while M_addr stays at the old value.
REQ-041 The bench SHALL cover Reset pulled low while in REQ -> all outputs reset immediately; a subsequent M_ack -> IR stays 0x0000.
REQ-042 The bench SHALL cover, with IF_HALT_DETECT_EN defined, fetch of 0x5000 -> Halted=1 and PC_up has no effect; PC_clr -> Halted=0, PC=0x00.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC register, IR register and IDLE/REQ/ERR fetch FSM with 16-cycle timeout.
// Optional HALT opcode detection (opcode 4'b0101) enabled by defining IF_HALT_DETECT_EN.
module instruction_fetch (
    input  logic        clk,
    input  logic        Reset,
    input  logic        PC_clr,
    input  logic        PC_up,
    input  logic        IR_ld,
    input  logic [15:0] M_data,
    input  logic        M_ack,
    output logic        M_rd_en,
    output logic [7:0]  M_addr,
    output logic [7:0]  PC,
    output logic [15:0] IR,
    output logic        IR_valid,
    output logic        Fetch_busy,
    output logic        Fetch_err,
    output logic        Halted,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] ERR  = 2'b10;

    // Memory handshake: M_rd_en is held high for the whole REQ state with a
    // stable M_addr; the first cycle M_ack is high while M_rd_en is high
    // completes the read. M_ack seen outside REQ is discarded.

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic       fetch_done;
    logic       halted_q;
    logic       pc_up_ok;

    assign fetch_done = (state == REQ) && M_ack;

`ifdef IF_HALT_DETECT_EN
    // A fetch that lands a HALT opcode wins over a simultaneous PC_clr.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            halted_q <= 1'b0;
        end else if (fetch_done && (M_data[15:12] == 4'b0101)) begin
            halted_q <= 1'b1;
        end else if (PC_clr) begin
            halted_q <= 1'b0;
        end
    end

    assign pc_up_ok = PC_up && !halted_q;
`else
    assign halted_q = 1'b0;
    assign pc_up_ok = PC_up;
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            PC <= 8'h00;
        end else if (PC_clr) begin
            PC <= 8'h00;
        end else if (pc_up_ok) begin
            PC <= PC + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            M_addr   <= 8'h00;
            IR       <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (IR_ld) begin
                        M_addr   <= PC;
                        wait_cnt <= 4'd0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (M_ack) begin
                        IR    <= M_data;
                        state <= IDLE;
                    end else if (wait_cnt == 4'hF) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion beats both the fetch-start clear and PC_clr.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            IR_valid <= 1'b0;
        end else if (fetch_done) begin
            IR_valid <= 1'b1;
        end else if ((state == IDLE) && IR_ld) begin
            IR_valid <= 1'b0;
        end else if (PC_clr) begin
            IR_valid <= 1'b0;
        end
    end

    assign M_rd_en    = (state == REQ);
    assign Fetch_busy = (state != IDLE);
    assign Fetch_err  = (state == ERR);
    assign Halted     = halted_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch plus hand-written sequences for
// timeout, PC wrap, reset mid-fetch and HALT detection (both macro settings).
module tb_instruction_fetch;

    logic        clk;
    logic        Reset;
    logic        PC_clr;
    logic        PC_up;
    logic        IR_ld;
    logic [15:0] M_data;
    logic        M_ack;
    logic        M_rd_en;
    logic [7:0]  M_addr;
    logic [7:0]  PC;
    logic [15:0] IR;
    logic        IR_valid;
    logic        Fetch_busy;
    logic        Fetch_err;
    logic        Halted;
    logic [1:0]  fsm_state;

    int n_pass;
    int n_total;

    instruction_fetch dut (
        .clk        (clk),
        .Reset      (Reset),
        .PC_clr     (PC_clr),
        .PC_up      (PC_up),
        .IR_ld      (IR_ld),
        .M_data     (M_data),
        .M_ack      (M_ack),
        .M_rd_en    (M_rd_en),
        .M_addr     (M_addr),
        .PC         (PC),
        .IR         (IR),
        .IR_valid   (IR_valid),
        .Fetch_busy (Fetch_busy),
        .Fetch_err  (Fetch_err),
        .Halted     (Halted),
        .fsm_state  (fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        up;
        logic        ld;
        logic        ack;
        logic [15:0] data;
        logic [7:0]  pc;
        logic [15:0] ir;
        logic        v;
        logic        rd;
        logic [7:0]  addr;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic up, logic ld, logic ack, logic [15:0] data,
                                logic [7:0] pc, logic [15:0] ir, logic v, logic rd,
                                logic [7:0] addr, logic busy, logic err);
        vec_t r;
        r.clr = clr; r.up = up; r.ld = ld; r.ack = ack; r.data = data;
        r.pc = pc; r.ir = ir; r.v = v; r.rd = rd; r.addr = addr; r.busy = busy; r.err = err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic clr, input logic up, input logic ld, input logic ack,
                         input logic [15:0] data);
        PC_clr = clr;
        PC_up  = up;
        IR_ld  = ld;
        M_ack  = ack;
        M_data = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    int          rd_cnt;
    int          err_cnt;
    logic [7:0]  pc_before;

    initial begin
        n_pass  = 0;
        n_total = 0;
        Reset   = 1'b0;
        idle_inputs();

        // Reset state
        #12;
        check("rst_pc", PC, 8'h00);
        check("rst_ir", IR, 16'h0000);
        check("rst_valid", IR_valid, 1'b0);
        check("rst_rd_en", M_rd_en, 1'b0);
        check("rst_busy", Fetch_busy, 1'b0);
        check("rst_err", Fetch_err, 1'b0);
        check("rst_halted", Halted, 1'b0);
        @(negedge clk);
        Reset = 1'b1;

        // Vector table: {clr, up, ld, ack, data} -> {pc, ir, valid, rd_en, addr, busy, err}
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 8'h01, 16'h0000, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 8'h02, 16'h0000, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 8'h03, 16'h0000, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 0));
        for (int i = 1; i <= 5; i++) begin
            vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 8'(i), 16'h0000, 0, 0, 8'h00, 0, 0));
        end
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h05, 16'h0000, 0, 1, 8'h05, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 8'h05, 16'h0000, 0, 1, 8'h05, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h3123, 8'h05, 16'h3123, 1, 0, 8'h05, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 8'h05, 16'h3123, 1, 0, 8'h05, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 8'h06, 16'h3123, 0, 1, 8'h05, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 8'h07, 16'h3123, 0, 1, 8'h05, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 16'h1234, 8'h08, 16'h1234, 1, 0, 8'h05, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 8'h00, 16'h1234, 0, 0, 8'h05, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'hBEEF, 8'h00, 16'h1234, 0, 0, 8'h05, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h00, 16'h1234, 0, 1, 8'h00, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0ABC, 8'h00, 16'h0ABC, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h00, 16'h0ABC, 0, 1, 8'h00, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 8'h01, 16'h0ABC, 0, 1, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h2222, 8'h01, 16'h2222, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 8'h01, 16'h2222, 1, 0, 8'h00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].up, vecs[i].ld, vecs[i].ack, vecs[i].data);
            tick();
            check($sformatf("v%0d_pc", i), PC, vecs[i].pc);
            check($sformatf("v%0d_ir", i), IR, vecs[i].ir);
            check($sformatf("v%0d_valid", i), IR_valid, vecs[i].v);
            check($sformatf("v%0d_rd_en", i), M_rd_en, vecs[i].rd);
            check($sformatf("v%0d_addr", i), M_addr, vecs[i].addr);
            check($sformatf("v%0d_busy", i), Fetch_busy, vecs[i].busy);
            check($sformatf("v%0d_err", i), Fetch_err, vecs[i].err);
        end
        idle_inputs();

        // PC wrap: 0x01 -> 0xFF -> 0x00
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 254; i++) tick();
        check("wrap_pc_ff", PC, 8'hFF);
        tick();
        check("wrap_pc_00", PC, 8'h00);
        idle_inputs();

        // Timeout: 16 REQ cycles, one ERR cycle, IR untouched
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        idle_inputs();
        rd_cnt  = 0;
        err_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (M_rd_en) rd_cnt++;
            if (Fetch_err) begin
                err_cnt++;
                check("to_err_busy", Fetch_busy, 1'b1);
                check("to_err_rd_en", M_rd_en, 1'b0);
                check("to_err_valid", IR_valid, 1'b0);
            end
            if (i < 24) tick();
        end
        check("to_rd_cycles", rd_cnt, 16);
        check("to_err_cycles", err_cnt, 1);
        check("to_ir", IR, 16'h2222);
        check("to_valid", IR_valid, 1'b0);
        check("to_busy_after", Fetch_busy, 1'b0);

        // Reset asserted mid-fetch, late M_ack ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        idle_inputs();
        check("mr_rd_en_before", M_rd_en, 1'b1);
        check("mr_addr_before", M_addr, 8'h02);
        #2;
        Reset = 1'b0;
        #1;
        check("mr_pc", PC, 8'h00);
        check("mr_ir", IR, 16'h0000);
        check("mr_valid", IR_valid, 1'b0);
        check("mr_rd_en", M_rd_en, 1'b0);
        check("mr_addr", M_addr, 8'h00);
        check("mr_busy", Fetch_busy, 1'b0);
        check("mr_err", Fetch_err, 1'b0);
        @(negedge clk);
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        tick();
        idle_inputs();
        check("mr_late_ack_ir", IR, 16'h0000);
        check("mr_late_ack_valid", IR_valid, 1'b0);
        check("mr_late_ack_busy", Fetch_busy, 1'b0);

        // HALT opcode fetch
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h5000);
        tick();
        idle_inputs();
        check("halt_ir", IR, 16'h5000);
        check("halt_valid", IR_valid, 1'b1);
        pc_before = PC;
        check("halt_pc_before", pc_before, 8'h02);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
`ifdef IF_HALT_DETECT_EN
        check("halt_flag", Halted, 1'b1);
        check("halt_pc_frozen", PC, 8'h02);
`else
        check("halt_flag_tied", Halted, 1'b0);
        check("halt_pc_advances", PC, 8'h03);
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        idle_inputs();
        check("halt_clr_flag", Halted, 1'b0);
        check("halt_clr_pc", PC, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        idle_inputs();
        check("halt_pc_up_after_clr", PC, 8'h01);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
